// File: rtl/gate_generator_if.sv
// Control and status bundle of the gate generator: requests in, gate/strobes/state out.
interface gate_generator_if #(
    parameter int CNT_WIDTH = 32,
    parameter int DIV_WIDTH = 5
);
    logic                 en;
    logic                 restart;
    logic [DIV_WIDTH-1:0] div;
    logic                 gate;
    logic                 gate_rise;
    logic                 period_done;
    logic [DIV_WIDTH-1:0] div_active;
    logic [CNT_WIDTH-1:0] phase;

    modport master (
        output en, restart, div,
        input  gate, gate_rise, period_done, div_active, phase
    );

    modport slave (
        input  en, restart, div,
        output gate, gate_rise, period_done, div_active, phase
    );
endinterface

// File: rtl/gate_generator.sv
// Programmable gate-time generator: owns a phase counter and emits a 50% duty gate of
// period 2^(k+1) clocks, with edge/period strobes and divider changes applied only at wrap.
module gate_generator #(
    parameter int CNT_WIDTH = 32,
    parameter int DIV_WIDTH = 5,
    parameter int OFFSET    = 26
) (
    input logic             clk,
    input logic             aresetn,
    gate_generator_if.slave bus
);
    localparam int KW = $clog2(CNT_WIDTH);

    logic [CNT_WIDTH-1:0] phase_reg, phase_next;
    logic [DIV_WIDTH-1:0] div_active_reg, div_active_next;
    logic                 gate_reg, gate_next;
    logic                 gate_rise_reg, gate_rise_next;
    logic                 period_done_reg, period_done_next;

    logic [KW-1:0]        k_cur, k_next;
    logic [CNT_WIDTH-1:0] low_mask;
    logic [CNT_WIDTH-1:0] rise_pat;
    logic                 terminal;

    // Dividers beyond OFFSET clamp to k=0 (two-clock period).
    function automatic logic [KW-1:0] k_of(input logic [DIV_WIDTH-1:0] d);
        if (32'(d) <= 32'(OFFSET))
            return KW'(32'(OFFSET) - 32'(d));
        return '0;
    endfunction

    assign k_cur = k_of(div_active_reg);

    genvar gi;
    generate
        for (gi = 0; gi < CNT_WIDTH; gi++) begin : g_mask
            assign low_mask[gi] = (32'(gi) <= 32'(k_cur));
            assign rise_pat[gi] = (32'(gi) == 32'(k_cur));
        end
    endgenerate

    assign terminal = ((phase_reg & low_mask) == low_mask);

    always_comb begin
        phase_next       = phase_reg;
        div_active_next  = div_active_reg;
        period_done_next = 1'b0;
        gate_rise_next   = 1'b0;
        if (bus.restart) begin
            phase_next      = '0;
            div_active_next = bus.div;
        end else if (bus.en) begin
            if (terminal) begin
                phase_next       = '0;
                div_active_next  = bus.div;
                period_done_next = 1'b1;
            end else begin
                phase_next     = phase_reg + CNT_WIDTH'(1);
                gate_rise_next = ((phase_next & low_mask) == rise_pat);
            end
        end
        k_next    = k_of(div_active_next);
        // The gate is its own flop so the output is free of index-mux glitches.
        gate_next = phase_next[k_next];
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phase_reg       <= '0;
            div_active_reg  <= '0;
            gate_reg        <= 1'b0;
            gate_rise_reg   <= 1'b0;
            period_done_reg <= 1'b0;
        end else begin
            phase_reg       <= phase_next;
            div_active_reg  <= div_active_next;
            gate_reg        <= gate_next;
            gate_rise_reg   <= gate_rise_next;
            period_done_reg <= period_done_next;
        end
    end

    assign bus.phase       = phase_reg;
    assign bus.div_active  = div_active_reg;
    assign bus.gate        = gate_reg;
    assign bus.gate_rise   = gate_rise_reg;
    assign bus.period_done = period_done_reg;
endmodule

// File: doc/gate_generator.md
Name: gate_generator

Overview:
- Programmable gate-time generator for the frequency counter; replaces the combinational bit-slice selector fed by an external free-running counter.
- Owns its counter and produces a glitch-free gate of period 2^(OFFSET-div+1) clocks with a 50% duty cycle.
- Adds edge/period strobes, a synchronous restart, and a divider change that takes effect only on a period boundary, so the downstream accumulator never sees a truncated gate.

Parameters:
- CNT_WIDTH, 32, internal counter width; must be > OFFSET.
- DIV_WIDTH, 5, width of the div select input.
- OFFSET, 26, gate bit index at div=0 (26 gives about 1.07 s full gate at 125 MHz).

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- en  in  1  count enable; counter holds when low.
- restart  in  1  synchronous restart pulse.
- div  in  DIV_WIDTH  requested divider; gate bit index = OFFSET-div.
- gate  out  1  gate level: low for the first half-period, high for the second.
- gate_rise  out  1  one-cycle strobe on the first cycle gate=1.
- period_done  out  1  one-cycle strobe on the first cycle of a new period (gate falling edge).
- div_active  out  DIV_WIDTH  divider currently in force.
- phase  out  CNT_WIDTH  current counter value.

Behaviour:
- Reset (aresetn=0, asynchronous): phase=0, div_active=0, gate=0, gate_rise=0, period_done=0.
- Index k = OFFSET-div_active when div_active <= OFFSET; otherwise k=0 (clamped; period 2 clocks).
- gate = phase[k]. This is a direct bit of a registered value with no combinational glitch path. Period is 2^(k+1) clocks.
- Terminal condition T: phase[k:0] all ones.
- Priority per rising clk edge: restart > en.
  - restart=1: phase<=0, div_active<=div, strobes<=0. Applies regardless of en.
  - en=1 and T: phase<=0, div_active<=div (sampled only here), period_done<=1.
  - en=1, not T: phase<=phase+1, period_done<=0.
  - en=0: phase, div_active and gate hold; both strobes 0.
- gate_rise: registered. Set to 1 when en=1, not T, and the next phase[k:0] = 1 followed by k zeros. Cleared on every other cycle.
- Strobe timing:
  - period_done is high in the same cycle phase reads 0 after the wrap.
  - gate_rise is high in the same cycle gate first reads 1.
  - Neither strobe is ever high for two consecutive cycles (with k=0 they alternate).
- A div change mid-period has no effect on gate, k or the strobes until the next wrap. Changes between wraps are not queued; the value present at the wrap wins.
- Bits of phase above k stay 0 in normal operation. They may only be nonzero transiently after reset of a larger-k configuration; the counter wraps only on T.
- aresetn asserted mid-period: immediate return to reset values. After release, the first period uses div_active=0 (k=OFFSET) until the first wrap or a restart.
- No overflow: phase never exceeds 2^(OFFSET+1)-1 < 2^CNT_WIDTH.

Test Plan:
- OFFSET=4, div=0, en=1 after reset -> gate 0 for phase 0..15, 1 for 16..31. gate_rise when phase=16. period_done when phase returns to 0 after 32 clocks. Repeats.
- div=2 applied at reset release -> first period still 32 clocks (div_active=0). After the wrap, div_active=2 and the period is 8 (4 low, 4 high); period_done every 8 clocks.
- div changed 2->1 at phase=3 -> current 8-clock period completes unchanged, then a 16-clock period. div changed 1->3->1 within one period -> period stays 16.
- div=7 with OFFSET=4 (clamp) -> k=0 after the wrap, gate toggles every clock. gate_rise and period_done alternate, each high every other cycle.
- en dropped at phase=10 for 5 clocks -> phase/gate frozen, no strobes. Resumes at 11. Period stretched to 37 clocks.
- restart at phase=20 with div=3 -> next cycle phase=0, div_active=3, no period_done. Pulse restart together with en=1 at T -> restart wins and no period_done. aresetn low mid-period -> all outputs 0 immediately.
